// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Holds FSM encoding, owner IDs and the word-address slice used on the memory side.
package dm_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int WADDR_MSB = 13;
  localparam int WADDR_LSB = 2;
  localparam int WADDR_W   = 12;
  localparam int CNT_W     = 4;

  function automatic logic [WADDR_W-1:0] word_addr(input logic [31:0] addr);
    return addr[WADDR_MSB:WADDR_LSB];
  endfunction

endpackage

// File: rtl/dm_prio_arb.sv
// CPU-priority arbiter with a starvation guard for the DMA requester.
// Purely combinational; the caller only samples it while idle.
module dm_prio_arb
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             cpu_req,
  input  logic             dma_req,
  input  logic [CNT_W-1:0] streak,
  output logic             grant_valid,
  output logic             grant_owner
);

  logic starve;

  always_comb begin
    // A zero limit means the CPU always wins a tie.
    starve      = (STARVE_LIMIT != 0) && (streak == CNT_W'(STARVE_LIMIT));
    grant_valid = cpu_req | dma_req;
    grant_owner = (dma_req && (!cpu_req || starve)) ? OWN_DMA : OWN_CPU;
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Arbitrates the single data-memory port between the CPU MEM stage and a DMA requester.
// Request to ack takes WAIT_CYCLES+2 cycles; the CPU is stalled until its ack.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [3:0]         cpu_be,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_ack,
  output logic               cpu_stall,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [3:0]         dma_be,
  input  logic [31:0]        dma_addr,
  input  logic [31:0]        dma_wdata,
  output logic [31:0]        dma_rdata,
  output logic               dma_ack,
  output logic               mem_en,
  output logic               mem_we,
  output logic [3:0]         mem_be,
  output logic [WADDR_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] streak;
  logic             own_q;
  logic             we_q;
  logic             grant_valid;
  logic             grant_owner;
  logic             sel_we;
  logic [3:0]       sel_be;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             sel_wr;
  logic             unused_addr_bits;

  dm_prio_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .streak     (streak),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  always_comb begin
    sel_we    = cpu_we;
    sel_be    = cpu_be;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_owner == OWN_DMA) begin
      sel_we    = dma_we;
      sel_be    = dma_be;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  assign sel_wr    = sel_we && (sel_be != 4'd0);
  assign cpu_stall = cpu_req & ~cpu_ack;

  assign unused_addr_bits = &{1'b0, cpu_addr[31:WADDR_MSB+1], cpu_addr[WADDR_LSB-1:0],
                              dma_addr[31:WADDR_MSB+1], dma_addr[WADDR_LSB-1:0]};

  // The mem_* outputs are the latched request itself, zeroed outside ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      streak    <= '0;
      own_q     <= OWN_CPU;
      we_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            own_q     <= grant_owner;
            we_q      <= sel_we;
            mem_en    <= 1'b1;
            mem_be    <= sel_be;
            mem_addr  <= word_addr(sel_addr);
            mem_wdata <= sel_wdata;
            mem_we    <= (WAIT_CYCLES == 0) && sel_wr;
            wait_cnt  <= CNT_W'(WAIT_CYCLES);
            if (grant_owner == OWN_DMA || !dma_req) begin
              streak <= '0;
            end else if (streak != '1) begin
              streak <= streak + 1'b1;
            end
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt == '0) begin
            if (own_q == OWN_DMA) dma_rdata <= mem_rdata;
            else                  cpu_rdata <= mem_rdata;
            cpu_ack   <= (own_q == OWN_CPU);
            dma_ack   <= (own_q == OWN_DMA);
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
            // Strobe only in the final cycle so each access writes at most once.
            mem_we   <= (wait_cnt == CNT_W'(1)) && we_q && (mem_be != 4'd0);
          end
        end
        ST_RESP: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: three instances (wait/starve = 1/2, 0/0, 15/4) against a
// schedule-based model, plus directed literal checks per scenario.
module tb_dm_access_ctrl;

  localparam int N = 3;
  localparam logic [11:0] WCV = {4'd15, 4'd0, 4'd1};
  localparam logic [11:0] SLV = {4'd4, 4'd0, 4'd2};

  function automatic int wc_of(input int g);
    return int'(WCV[g*4 +: 4]);
  endfunction
  function automatic int sl_of(input int g);
    return int'(SLV[g*4 +: 4]);
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req [N];
  logic        cpu_we [N];
  logic [3:0]  cpu_be [N];
  logic [31:0] cpu_addr [N];
  logic [31:0] cpu_wdata [N];
  logic [31:0] cpu_rdata [N];
  logic        cpu_ack [N];
  logic        cpu_stall [N];
  logic        dma_req [N];
  logic        dma_we [N];
  logic [3:0]  dma_be [N];
  logic [31:0] dma_addr [N];
  logic [31:0] dma_wdata [N];
  logic [31:0] dma_rdata [N];
  logic        dma_ack [N];
  logic        mem_en [N];
  logic        mem_we [N];
  logic [3:0]  mem_be [N];
  logic [11:0] mem_addr [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dm_access_ctrl #(
      .WAIT_CYCLES (WCV[g*4 +: 4]),
      .STARVE_LIMIT(SLV[g*4 +: 4])
    ) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_be(cpu_be[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
      .cpu_stall(cpu_stall[g]),
      .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_be(dma_be[g]), .dma_addr(dma_addr[g]),
      .dma_wdata(dma_wdata[g]), .dma_rdata(dma_rdata[g]), .dma_ack(dma_ack[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
  end

  int total = 0;
  int bad = 0;
  int tc = 0;

  task automatic check(input string nm, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", nm, g, act, exp);
    end
  endtask

  always @(posedge clk) tc <= tc + 1;

  // Model: an access granted at the end of idle cycle c occupies cycles c+1..c+1+W
  // on the memory side and acks in cycle c+2+W.
  int unsigned mc = 0;
  bit          m_busy [N];
  bit          m_own [N];
  bit          m_we [N];
  logic [3:0]  m_be [N];
  logic [11:0] m_addr [N];
  logic [31:0] m_wd [N];
  logic [31:0] m_crd [N];
  logic [31:0] m_drd [N];
  int unsigned m_end [N];
  int          m_streak [N];
  bit          dw;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < N; g++) begin
        m_busy[g]   <= 1'b0;
        m_streak[g] <= 0;
        m_crd[g]    <= '0;
        m_drd[g]    <= '0;
      end
    end else begin
      for (int g = 0; g < N; g++) begin
        if (m_busy[g] && mc == m_end[g]) begin
          if (m_own[g]) m_drd[g] <= mem_rdata[g];
          else          m_crd[g] <= mem_rdata[g];
        end
        if (!m_busy[g] || mc > m_end[g] + 1) begin
          m_busy[g] <= 1'b0;
          if (cpu_req[g] || dma_req[g]) begin
            dw = dma_req[g] && (!cpu_req[g] || (sl_of(g) != 0 && m_streak[g] == sl_of(g)));
            m_busy[g] <= 1'b1;
            m_own[g]  <= dw;
            m_end[g]  <= mc + 1 + wc_of(g);
            m_we[g]   <= dw ? dma_we[g] : cpu_we[g];
            m_be[g]   <= dw ? dma_be[g] : cpu_be[g];
            m_addr[g] <= dw ? dma_addr[g][13:2] : cpu_addr[g][13:2];
            m_wd[g]   <= dw ? dma_wdata[g] : cpu_wdata[g];
            if (dw || !dma_req[g]) m_streak[g] <= 0;
            else if (m_streak[g] < 15) m_streak[g] <= m_streak[g] + 1;
          end
        end
      end
      mc <= mc + 1;
    end
  end

  int          en_cnt [N];
  int          we_cnt [N];
  int          ack_n [N];
  logic [63:0] ack_bits [N];
  logic [11:0] last_addr [N];
  logic [11:0] we_addr [N];
  logic [3:0]  we_be [N];
  logic [31:0] we_data [N];
  int          overlap = 0;
  bit          e_acc, e_lst, e_rsp;

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      e_acc = m_busy[g] && (mc <= m_end[g]);
      e_lst = e_acc && (mc == m_end[g]);
      e_rsp = m_busy[g] && (mc == m_end[g] + 1);
      check("mem_en", g, mem_en[g], e_acc);
      check("mem_we", g, mem_we[g], e_lst && m_we[g] && (m_be[g] != 4'd0));
      check("mem_be", g, mem_be[g], e_acc ? m_be[g] : 4'd0);
      check("mem_addr", g, mem_addr[g], e_acc ? m_addr[g] : 12'd0);
      check("mem_wdata", g, mem_wdata[g], e_acc ? m_wd[g] : 32'd0);
      check("cpu_ack", g, cpu_ack[g], e_rsp && !m_own[g]);
      check("dma_ack", g, dma_ack[g], e_rsp && m_own[g]);
      check("cpu_rdata", g, cpu_rdata[g], m_crd[g]);
      check("dma_rdata", g, dma_rdata[g], m_drd[g]);
      check("cpu_stall", g, cpu_stall[g], cpu_req[g] && !(e_rsp && !m_own[g]));
      if (mem_en[g]) begin
        en_cnt[g]    <= en_cnt[g] + 1;
        last_addr[g] <= mem_addr[g];
      end
      if (mem_we[g]) begin
        we_cnt[g]  <= we_cnt[g] + 1;
        we_addr[g] <= mem_addr[g];
        we_be[g]   <= mem_be[g];
        we_data[g] <= mem_wdata[g];
      end
      if ((cpu_ack[g] || dma_ack[g]) && ack_n[g] < 64) begin
        ack_bits[g][ack_n[g]] <= dma_ack[g];
        ack_n[g] <= ack_n[g] + 1;
      end
      if (cpu_ack[g] && dma_ack[g]) overlap <= overlap + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  // Issues one CPU access and holds req until the ack; optionally scrambles cpu_addr
  // at wait iteration chg_at to show the latched copy is what reaches memory.
  task automatic cpu_access(input int g, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int chg_at,
                            output int lat, output int stall_n);
    int t0;
    mem_rdata[g] = rd;
    cpu_we[g]    = we;
    cpu_be[g]    = be;
    cpu_addr[g]  = addr;
    cpu_wdata[g] = wd;
    cpu_req[g]   = 1'b1;
    t0      = tc;
    lat     = -1;
    stall_n = 0;
    for (int i = 0; i < 40; i++) begin
      wait_neg();
      if (i == chg_at) cpu_addr[g] = ~addr;
      if (cpu_stall[g]) stall_n++;
      if (cpu_ack[g]) begin
        lat = tc - t0;
        break;
      end
    end
    step();
    cpu_req[g] = 1'b0;
  endtask

  initial begin
    int lat, stn, b_en, b_we, b_ack, t0;
    for (int g = 0; g < N; g++) begin
      cpu_req[g] = 0; cpu_we[g] = 0; cpu_be[g] = 0; cpu_addr[g] = 0; cpu_wdata[g] = 0;
      dma_req[g] = 0; dma_we[g] = 0; dma_be[g] = 0; dma_addr[g] = 0; dma_wdata[g] = 0;
      mem_rdata[g] = 0;
    end
    repeat (2) wait_neg();
    check("rst_mem_en", 0, mem_en[0], 0);
    check("rst_cpu_ack", 0, cpu_ack[0], 0);
    check("rst_mem_addr", 2, mem_addr[2], 0);
    @(posedge clk);
    #3 reset = 1'b1;
    step();

    // CPU read, one wait cycle
    b_en = en_cnt[0];
    b_we = we_cnt[0];
    cpu_access(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, -1, lat, stn);
    check("A_latency", 0, lat, 3);
    check("A_stall_cycles", 0, stn, 3);
    check("A_rdata", 0, cpu_rdata[0], 32'hDEAD_BEEF);
    check("A_en_cycles", 0, en_cnt[0] - b_en, 2);
    check("A_we_pulses", 0, we_cnt[0] - b_we, 0);
    check("A_mem_addr", 0, last_addr[0], 12'h004);

    // CPU partial write, then a write with no byte enables
    b_we = we_cnt[0];
    cpu_access(0, 1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678, 32'h0, -1, lat, stn);
    check("B_we_pulses", 0, we_cnt[0] - b_we, 1);
    check("B_we_be", 0, we_be[0], 4'b0011);
    check("B_we_addr", 0, we_addr[0], 12'h008);
    check("B_we_data", 0, we_data[0], 32'h1234_5678);
    check("B_latency", 0, lat, 3);
    b_we = we_cnt[0];
    cpu_access(0, 1'b1, 4'b0000, 32'h0000_0024, 32'hFFFF_FFFF, 32'h0, -1, lat, stn);
    check("B_be0_we_pulses", 0, we_cnt[0] - b_we, 0);
    check("B_be0_latency", 0, lat, 3);

    // Both requesting with starve limit 2
    b_ack = ack_n[0];
    mem_rdata[0] = 32'h0BAD_F00D;
    cpu_we[0] = 0; cpu_be[0] = 4'hF; cpu_addr[0] = 32'h40;
    dma_we[0] = 0; dma_be[0] = 4'hF; dma_addr[0] = 32'h80;
    cpu_req[0] = 1; dma_req[0] = 1;
    for (int i = 0; i < 80; i++) begin
      wait_neg();
      if (ack_n[0] - b_ack >= 6) break;
    end
    step();
    cpu_req[0] = 0; dma_req[0] = 0;
    check("C_ack_count", 0, ack_n[0] - b_ack, 6);
    check("C_grant_order", 0, 32'((ack_bits[0] >> b_ack) & 64'h3F), 32'b100100);
    check("C_ack_overlap", 0, overlap, 0);

    // Zero wait cycles, strict CPU priority
    cpu_access(1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hCAFE_0001, -1, lat, stn);
    check("D_latency_w0", 1, lat, 2);
    check("D_stall_cycles", 1, stn, 2);
    check("D_rdata", 1, cpu_rdata[1], 32'hCAFE_0001);
    b_ack = ack_n[1];
    mem_rdata[1] = 32'h5A5A_0002;
    dma_we[1] = 0; dma_be[1] = 4'hF; dma_addr[1] = 32'h200;
    cpu_req[1] = 1; dma_req[1] = 1;
    for (int i = 0; i < 60; i++) begin
      wait_neg();
      if (ack_n[1] - b_ack >= 5) break;
    end
    check("D_cpu_acks", 1, ack_n[1] - b_ack, 5);
    check("D_no_dma_grant", 1, 32'((ack_bits[1] >> b_ack) & 64'h1F), 0);
    step();
    cpu_req[1] = 0;
    t0  = tc;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      wait_neg();
      if (dma_ack[1]) begin
        lat = tc - t0;
        break;
      end
    end
    step();
    dma_req[1] = 0;
    check("D_dma_latency", 1, lat, 2);
    check("D_dma_rdata", 1, dma_rdata[1], 32'h5A5A_0002);

    // Fifteen wait cycles with the CPU address changing mid-access
    b_en = en_cnt[2];
    cpu_access(2, 1'b0, 4'hF, 32'h0000_3FFC, 32'h0, 32'h1357_9BDF, 3, lat, stn);
    check("E_latency_w15", 2, lat, 17);
    check("E_stall_cycles", 2, stn, 17);
    check("E_en_cycles", 2, en_cnt[2] - b_en, 16);
    check("E_addr_held", 2, last_addr[2], 12'hFFF);
    check("E_rdata", 2, cpu_rdata[2], 32'h1357_9BDF);

    // Reset in the middle of a DMA write
    b_we  = we_cnt[0];
    b_ack = ack_n[0];
    dma_we[0] = 1; dma_be[0] = 4'hF; dma_addr[0] = 32'h44; dma_wdata[0] = 32'hA5A5_5A5A;
    dma_req[0] = 1;
    step();
    #2 reset = 1'b0;
    #1;
    check("F_rst_mem_en", 0, mem_en[0], 0);
    check("F_rst_mem_we", 0, mem_we[0], 0);
    check("F_rst_mem_addr", 0, mem_addr[0], 0);
    check("F_rst_mem_wdata", 0, mem_wdata[0], 0);
    check("F_rst_mem_be", 0, mem_be[0], 0);
    check("F_rst_dma_ack", 0, dma_ack[0], 0);
    check("F_rst_cpu_rdata", 0, cpu_rdata[0], 0);
    dma_req[0] = 0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    step();
    check("F_no_write", 0, we_cnt[0] - b_we, 0);
    check("F_no_ack", 0, ack_n[0] - b_ack, 0);
    cpu_access(0, 1'b0, 4'hF, 32'h0000_0030, 32'h0, 32'h2468_ACE0, -1, lat, stn);
    check("F_after_latency", 0, lat, 3);
    check("F_after_rdata", 0, cpu_rdata[0], 32'h2468_ACE0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
